// File: rtl/cpu_types_pkg.sv
// Shared MIPS core types: word and opcode definitions, instruction formats and fetch FSM states.
package cpu_types_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [5:0] {
        RTYPE = 6'h00,
        J     = 6'h02,
        JAL   = 6'h03,
        BEQ   = 6'h04,
        BNE   = 6'h05,
        ADDI  = 6'h08,
        ADDIU = 6'h09,
        SLTI  = 6'h0A,
        SLTIU = 6'h0B,
        ANDI  = 6'h0C,
        ORI   = 6'h0D,
        XORI  = 6'h0E,
        LUI   = 6'h0F,
        LW    = 6'h23,
        SW    = 6'h2B,
        LL    = 6'h30,
        SC    = 6'h38,
        HALT  = 6'h3F
    } opcode_t;

    typedef struct packed {
        opcode_t     opcode;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [15:0] imm;
    } i_t;

    typedef struct packed {
        opcode_t     opcode;
        logic [25:0] addr;
    } j_t;

    typedef enum logic [1:0] {
        PC_SEL_SEQ    = 2'b00,
        PC_SEL_REG    = 2'b01,
        PC_SEL_JUMP   = 2'b10,
        PC_SEL_BRANCH = 2'b11
    } pc_sel_t;

    typedef enum logic [1:0] {
        IFETCH = 2'd0,
        EXEC   = 2'd1,
        DMEM   = 2'd2,
        HALTED = 2'd3
    } fetch_state_t;

    // Word-aligned byte offset of a branch immediate.
    function automatic word_t branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: sequential, register (JR), jump and conditional branch.
module next_pc_calc
    import cpu_types_pkg::*;
(
    input  word_t       pc,
    input  word_t       instr,
    input  logic [1:0]  pc_sel,
    input  logic        zero,
    input  word_t       rs_data,
    output word_t       next_pc
);

    word_t   w_pc_plus4;
    opcode_t w_opcode;
    logic    w_taken;
    logic    w_unused_rs_lsb;

    assign w_pc_plus4 = pc + 32'd4;
    assign w_opcode   = opcode_t'(instr[31:26]);
    assign w_taken    = ((w_opcode == BEQ) && zero) || ((w_opcode == BNE) && !zero);

    // JR forces word alignment, so the low target bits are dropped.
    assign w_unused_rs_lsb = ^rs_data[1:0];

    always_comb begin
        next_pc = w_pc_plus4;
        unique case (pc_sel_t'(pc_sel))
            PC_SEL_SEQ:    next_pc = w_pc_plus4;
            PC_SEL_REG:    next_pc = {rs_data[31:2], 2'b00};
            PC_SEL_JUMP:   next_pc = {w_pc_plus4[31:28], instr[25:0], 2'b00};
            PC_SEL_BRANCH: next_pc = w_taken ? (w_pc_plus4 + branch_offset(instr[15:0]))
                                             : w_pc_plus4;
        endcase
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch / memory-request sequencer: owns the PC and current instruction and
// steps each instruction through fetch, execute, optional data access and commit.
module fetch_sequencer
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  word_t       imemload,
    input  logic        dhit,
    input  logic [1:0]  pc_sel,
    input  logic        memREN,
    input  logic        memWEN,
    input  logic        halt,
    input  logic        zero,
    input  word_t       rs_data,
    output logic        imemREN,
    output word_t       imemaddr,
    output logic        dmemREN,
    output logic        dmemWEN,
    output word_t       instr,
    output word_t       pc_plus4,
    output logic        commit,
    output logic        halted
);

    fetch_state_t r_state;
    word_t        r_pc;
    word_t        r_instr;
    word_t        w_next_pc;
    logic         w_mem_op;
    logic         w_exec_retire;
    logic         w_dmem_retire;

    next_pc_calc u_next_pc (
        .pc      (r_pc),
        .instr   (r_instr),
        .pc_sel  (pc_sel),
        .zero    (zero),
        .rs_data (rs_data),
        .next_pc (w_next_pc)
    );

    assign w_mem_op      = memREN | memWEN;
    // halt wins over a memory op, so a halting store never reaches DMEM.
    assign w_exec_retire = (r_state == EXEC) && !halt && !w_mem_op;
    assign w_dmem_retire = (r_state == DMEM) && dhit;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= IFETCH;
            r_pc    <= PC_INIT;
            r_instr <= '0;
        end else begin
            unique case (r_state)
                IFETCH: begin
                    if (ihit) begin
                        r_instr <= imemload;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    if (halt) begin
                        r_state <= HALTED;
                    end else if (w_mem_op) begin
                        r_state <= DMEM;
                    end else begin
                        r_pc    <= w_next_pc;
                        r_state <= IFETCH;
                    end
                end
                DMEM: begin
                    if (dhit) begin
                        r_pc    <= w_next_pc;
                        r_state <= IFETCH;
                    end
                end
                HALTED: begin
                    r_state <= HALTED;
                end
            endcase
        end
    end

    assign imemREN  = (r_state == IFETCH);
    assign dmemREN  = (r_state == DMEM) && memREN;
    assign dmemWEN  = (r_state == DMEM) && memWEN;
    assign commit   = w_exec_retire || w_dmem_retire;
    assign halted   = (r_state == HALTED);
    assign imemaddr = r_pc;
    assign pc_plus4 = r_pc + 32'd4;
    assign instr    = r_instr;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed table-driven bench for fetch_sequencer plus hand-written reset corner cases.
module tb_fetch_sequencer;
    import cpu_types_pkg::*;

    localparam logic [31:0] W_ADDI = 32'h2000_0001;
    localparam logic [31:0] W_BEQ  = 32'h1000_FFFF;
    localparam logic [31:0] W_BNE  = 32'h1400_FFFF;
    localparam logic [31:0] W_LW   = 32'h8C00_0000;
    localparam logic [31:0] W_SW   = 32'hAC00_0000;
    localparam logic [31:0] W_J    = 32'h0800_0040;
    localparam logic [31:0] W_JR   = 32'h0000_0008;

    typedef struct {
        logic        ih;
        logic [31:0] iload;
        logic        dh;
        logic [1:0]  sel;
        logic        ren, wen, hlt, z;
        logic [31:0] rs;
        logic        e_iren, e_dren, e_dwen, e_com, e_halted;
        logic [31:0] e_addr, e_instr;
    } vec_t;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        ihit, dhit, memREN, memWEN, halt, zero;
    logic [1:0]  pc_sel;
    logic [31:0] imemload, rs_data;
    logic        imemREN, dmemREN, dmemWEN, commit, halted;
    logic [31:0] imemaddr, instr, pc_plus4;

    int total = 0;
    int bad   = 0;
    vec_t vecs[$];

    always #5 CLK = ~CLK;

    fetch_sequencer dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .ihit     (ihit),
        .imemload (imemload),
        .dhit     (dhit),
        .pc_sel   (pc_sel),
        .memREN   (memREN),
        .memWEN   (memWEN),
        .halt     (halt),
        .zero     (zero),
        .rs_data  (rs_data),
        .imemREN  (imemREN),
        .imemaddr (imemaddr),
        .dmemREN  (dmemREN),
        .dmemWEN  (dmemWEN),
        .instr    (instr),
        .pc_plus4 (pc_plus4),
        .commit   (commit),
        .halted   (halted)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic ih, input logic [31:0] iload, input logic dh,
                                input logic [1:0] sel, input logic ren, input logic wen,
                                input logic hlt, input logic z, input logic [31:0] rs,
                                input logic iren, input logic dren, input logic dwen,
                                input logic com, input logic hd, input logic [31:0] addr,
                                input logic [31:0] ins);
        vec_t v;
        v.ih = ih; v.iload = iload; v.dh = dh; v.sel = sel;
        v.ren = ren; v.wen = wen; v.hlt = hlt; v.z = z; v.rs = rs;
        v.e_iren = iren; v.e_dren = dren; v.e_dwen = dwen; v.e_com = com;
        v.e_halted = hd; v.e_addr = addr; v.e_instr = ins;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        ihit = v.ih; imemload = v.iload; dhit = v.dh; pc_sel = v.sel;
        memREN = v.ren; memWEN = v.wen; halt = v.hlt; zero = v.z; rs_data = v.rs;
    endtask

    task automatic check_row(input int i, input vec_t v);
        string p;
        p = $sformatf("row%0d", i);
        chk({p, " imemREN"}, 32'(imemREN), 32'(v.e_iren));
        chk({p, " dmemREN"}, 32'(dmemREN), 32'(v.e_dren));
        chk({p, " dmemWEN"}, 32'(dmemWEN), 32'(v.e_dwen));
        chk({p, " commit"}, 32'(commit), 32'(v.e_com));
        chk({p, " halted"}, 32'(halted), 32'(v.e_halted));
        chk({p, " imemaddr"}, imemaddr, v.e_addr);
        chk({p, " pc_plus4"}, pc_plus4, v.e_addr + 32'd4);
        chk({p, " instr"}, instr, v.e_instr);
    endtask

    task automatic idle_inputs();
        ihit = 0; imemload = 0; dhit = 0; pc_sel = 2'b00;
        memREN = 0; memWEN = 0; halt = 0; zero = 0; rs_data = 0;
    endtask

    initial begin
        idle_inputs();
        nRST = 1'b1;
        #1 nRST = 1'b0;
        #2;
        chk("rst imemREN", 32'(imemREN), 32'd1);
        chk("rst imemaddr", imemaddr, 32'h0);
        chk("rst instr", instr, 32'h0);
        chk("rst commit", 32'(commit), 32'd0);
        chk("rst halted", 32'(halted), 32'd0);
        chk("rst dmemREN", 32'(dmemREN), 32'd0);
        chk("rst state", 32'(dut.r_state), 32'(IFETCH));

        // ih iload dh sel ren wen hlt z rs | iren dren dwen com halted addr instr
        vecs.push_back(mk(1, W_ADDI, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h00, 32'h0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h00, W_ADDI));
        vecs.push_back(mk(1, W_ADDI, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h04, W_ADDI));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h04, W_ADDI));
        vecs.push_back(mk(1, W_ADDI, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h08, W_ADDI));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h08, W_ADDI));
        vecs.push_back(mk(0, W_BEQ, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h0C, W_ADDI));
        vecs.push_back(mk(1, W_ADDI, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h0C, W_ADDI));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0C, W_ADDI));
        vecs.push_back(mk(1, W_BEQ, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h10, W_ADDI));
        vecs.push_back(mk(0, 0, 0, 3, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 32'h10, W_BEQ));
        vecs.push_back(mk(1, W_BEQ, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h10, W_BEQ));
        vecs.push_back(mk(0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h10, W_BEQ));
        vecs.push_back(mk(1, W_BNE, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h14, W_BEQ));
        vecs.push_back(mk(0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h14, W_BNE));
        vecs.push_back(mk(1, W_BNE, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h14, W_BNE));
        vecs.push_back(mk(0, 0, 0, 3, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 32'h14, W_BNE));
        vecs.push_back(mk(1, W_LW, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h18, W_BNE));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h18, W_LW));
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h18, W_LW));
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h18, W_LW));
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h18, W_LW));
        vecs.push_back(mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 32'h18, W_LW));
        vecs.push_back(mk(1, W_JR, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h1C, W_LW));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 32'h8000_0003, 0, 0, 0, 1, 0, 32'h1C, W_JR));
        vecs.push_back(mk(1, W_J, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h8000_0000, W_JR));
        vecs.push_back(mk(0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h8000_0000, W_J));
        vecs.push_back(mk(1, W_JR, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h8000_0100, W_J));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 32'h123, 0, 0, 0, 1, 0, 32'h8000_0100, W_JR));
        vecs.push_back(mk(1, W_SW, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h120, W_JR));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h120, W_SW));
        vecs.push_back(mk(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 32'h120, W_SW));
        vecs.push_back(mk(1, W_SW, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h124, W_SW));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 32'h124, W_SW));
        for (int k = 0; k < 3; k++) begin
            vecs.push_back(mk(1, W_ADDI, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h124, W_SW));
        end

        @(negedge CLK);
        nRST = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            #1;
            check_row(i, vecs[i]);
            @(negedge CLK);
        end

        // Reset out of HALTED, then drop nRST in the middle of a load's data access.
        idle_inputs();
        nRST = 1'b0;
        #1;
        chk("unhalt halted", 32'(halted), 32'd0);
        chk("unhalt imemaddr", imemaddr, 32'h0);
        @(negedge CLK);
        nRST = 1'b1;
        ihit = 1; imemload = W_LW;
        @(negedge CLK);
        ihit = 0; memREN = 1;
        @(negedge CLK);
        #1;
        chk("dmem state", 32'(dut.r_state), 32'(DMEM));
        chk("dmem dmemREN", 32'(dmemREN), 32'd1);
        chk("dmem imemREN", 32'(imemREN), 32'd0);
        #1 nRST = 1'b0;
        #1;
        chk("async state", 32'(dut.r_state), 32'(IFETCH));
        chk("async imemaddr", imemaddr, 32'h0);
        chk("async dmemREN", 32'(dmemREN), 32'd0);
        chk("async instr", instr, 32'h0);
        chk("async imemREN", 32'(imemREN), 32'd1);
        chk("async commit", 32'(commit), 32'd0);

        @(negedge CLK);
        nRST = 1'b1;
        memREN = 0;
        ihit = 1; imemload = W_ADDI;
        @(negedge CLK);
        ihit = 0;
        #1;
        chk("recover commit", 32'(commit), 32'd1);
        chk("recover instr", instr, W_ADDI);
        @(negedge CLK);
        #1;
        chk("recover imemaddr", imemaddr, 32'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
